barrel_shifter_pipe: RTL and testbench
======================================

# barrel_shifter_pipe

Parametrised, pipelined barrel shifter with a valid/ready stream interface on both sides. It is the multi-mode successor to the DCE06 8-bit mux-tree shifter. One log-shift stage per shift-amount bit, each stage registered, with full-throughput backpressure. It sits between an operand source (register file or test driver) and a result sink (ALU writeback or display logic).

## Interface
- WIDTH, 8, data width; power of two, ≥ 2
- SHW, $clog2(WIDTH), shift-amount width; also the number of pipeline stages
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration)
- out_valid  output  1  result present
- out_ready  input  1  sink accepts the result this cycle
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0; qualified by out_valid

## Operation
- Transfer on a port occurs when valid && ready are both high at a rising edge.
- Stage k (k = 0..SHW-1) holds valid_k, data_k, shamt_k and mode_k.
- Stage k shifts by 2^k when shamt bit k is 1; otherwise it passes data through.
- Shamt and mode travel down the pipeline alongside the data.
- SLL: zero fill from the LSB.
- SRL: zero fill from the MSB.
- SRA: MSB-of-operand fill. The fill bit is the current stage data MSB, which is invariant across SRA stages.
- ROR: bits leaving the LSB re-enter at the MSB.
- in_shamt = 0 gives out_data = in_data for every mode.
- out_zero is computed from the final stage's combinational result and registered with it.
- Backpressure:
  - ready_SHW = out_ready
  - ready_k = !valid_{k+1} || ready_{k+1}
  - in_ready = !valid_0 || ready_1, i.e. stage 0 register is free or advancing.
- Stage register loads when its upstream transfers. Its valid clears when it hands off without a new load.
- Bubbles collapse: an empty stage accepts data even if downstream is stalled.
- Data held in a stalled stage stays stable until it is consumed.
- No beat may be dropped or duplicated; order is preserved.

## Timing
- Latency:
  - A beat accepted at edge t appears with out_valid = 1 after edge t+SHW-1, i.e. SHW register stages.
  - With the default WIDTH = 8, out_valid rises 3 cycles after acceptance.
- Throughput: 1 beat/cycle when out_ready is held high.
- The in_ready combinational path runs from out_ready through the stage valids. There is no path from in_valid to in_ready.
- Reset values: out_valid 0, out_data 0, out_zero 0, all stage valids 0. in_ready therefore reads 1 during and after reset.
- Reset mid-stream discards all in-flight beats at the reset edge. No output transfer occurs in that cycle.
- Simultaneous accept and emit in the same cycle with a full pipe is legal and required to sustain throughput.

## Configuration
- BSHIFT_ROTATE_EN defined: mode 11 performs ROR.
- BSHIFT_ROTATE_EN undefined:
  - Rotate logic is not built.
  - Mode 11 behaves exactly as SRL (01).
  - All other modes and timing are unchanged.

## Structure
- Shared package bshift_pkg holds:
  - mode constants BSH_SLL = 2'b00, BSH_SRL = 2'b01, BSH_SRA = 2'b10, BSH_ROR = 2'b11
  - a stage payload struct {data, shamt, mode}
- Sub-module barrel_stage, parametrised by WIDTH and STAGE index:
  - one combinational 2^k shift
  - payload/valid register with load/hold/clear
- The top level generates SHW instances and the ready chain.

## Test plan
- WIDTH=8, out_ready=1, data 0x96, shamt 3, one beat per mode:
  - SLL → 0xB0
  - SRL → 0x12
  - SRA → 0xF2
  - ROR → 0xD2 (0x12 with BSHIFT_ROTATE_EN undefined)
  - each result appears exactly 3 cycles after acceptance.
- shamt 0, data 0x5A, all modes → 0x5A. SLL of 0x80 by 1 → 0x00 with out_zero = 1.
- Back-to-back stream of 16 random beats, out_ready=1 → 16 results in order on consecutive cycles, each matching the reference model.
- Stall test:
  - Fill the pipe, hold out_ready=0 for 5 cycles: in_ready drops after 3 accepted beats and out_data stays stable.
  - Release out_ready: all beats are delivered in order with no loss or duplication.
- Random in_valid/out_ready toggling, 1000 beats → scoreboard matches. Protocol assertion: out_data is stable while out_valid && !out_ready.
- Assert rst for 1 cycle with 2 beats in flight → out_valid = 0 the next cycle, no stale result ever emitted, in_ready = 1.

Source files
------------

// File: rtl/bshift_pkg.sv
// bshift_pkg: shared definitions for the pipelined barrel shifter.
//   Mode encodings carried alongside each beat through the pipeline.
//   The per-stage payload (data, shamt, mode) is width-dependent, so each
//   stage declares its own packed payload struct from its WIDTH/SHW parameters.
package bshift_pkg;

  localparam logic [1:0] BSH_SLL = 2'b00;
  localparam logic [1:0] BSH_SRL = 2'b01;
  localparam logic [1:0] BSH_SRA = 2'b10;
  localparam logic [1:0] BSH_ROR = 2'b11;

endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one log-shift stage of the barrel shifter pipeline.
//   Shifts the upstream payload by 2^STAGE when shamt bit STAGE is set,
//   then registers payload + valid with load / hold / clear behaviour.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid / o_ready        upstream handshake (o_ready = register free or advancing)
//   i_data/i_shamt/i_mode    upstream payload
//   o_valid / i_ready        downstream handshake
//   o_data/o_shamt/o_mode    registered payload
//   o_zero                   registered (shifted data == 0)
// Macro: BSHIFT_ROTATE_EN builds the ROR path; without it mode 11 acts as SRL.
module barrel_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [SHW-1:0]   o_shamt,
  output logic [1:0]       o_mode,
  output logic             o_zero
);

  localparam int SH = 1 << STAGE;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [1:0]       mode;
  } payload_t;

  payload_t         r_pl;
  logic             r_valid;
  logic             r_zero;
  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = i_data;
    if (i_shamt[STAGE]) begin
      case (i_mode)
        BSH_SLL: w_shifted = i_data << SH;
        // The operand MSB survives every SRA stage, so the local MSB is the sign.
        BSH_SRA: w_shifted = {{SH{i_data[WIDTH-1]}}, i_data[WIDTH-1:SH]};
`ifdef BSHIFT_ROTATE_EN
        BSH_ROR: w_shifted = {i_data[SH-1:0], i_data[WIDTH-1:SH]};
`endif
        default: w_shifted = i_data >> SH;
      endcase
    end
  end

  // Free or handing off this cycle; no dependence on i_valid.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pl    <= '0;
      r_zero  <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_pl.data  <= w_shifted;
        r_pl.shamt <= i_shamt;
        r_pl.mode  <= i_mode;
        r_zero     <= (w_shifted == '0);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_pl.data;
  assign o_shamt = r_pl.shamt;
  assign o_mode  = r_pl.mode;
  assign o_zero  = r_zero;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: SHW-stage pipelined barrel shifter (SLL/SRL/SRA/ROR)
//   with valid/ready on both sides and full-throughput backpressure.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_data/in_shamt    operand and shift amount
//   in_mode             00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid/out_ready result handshake
//   out_data, out_zero  result and (result == 0)
// Macro: BSHIFT_ROTATE_EN enables ROR; when undefined mode 11 behaves as SRL.
module barrel_shifter_pipe
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index k is the input side of stage k; index SHW is the pipeline output.
  logic             w_valid [SHW+1];
  logic             w_ready [SHW+1];
  logic [WIDTH-1:0] w_data  [SHW+1];
  logic [SHW-1:0]   w_shamt [SHW+1];
  logic [1:0]       w_mode  [SHW+1];
  logic [SHW-1:0]   w_zero;
  logic             w_unused;

  assign w_valid[0]   = in_valid;
  assign w_data[0]    = in_data;
  assign w_shamt[0]   = in_shamt;
  assign w_mode[0]    = in_mode;
  assign w_ready[SHW] = out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_mode  (w_mode[k]),
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_zero  (w_zero[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[SHW];
  assign out_data  = w_data[SHW];
  assign out_zero  = w_zero[SHW-1];

  // Only the last stage's zero flag matters; the rest, plus the final
  // shamt/mode, are intentionally left unconsumed.
  assign w_unused = ^{w_zero, w_shamt[SHW], w_mode[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;
  import bshift_pkg::*;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

`ifdef BSHIFT_ROTATE_EN
  localparam logic [7:0] ROR_96_3 = 8'hD2;
  localparam logic [7:0] ROR_01_1 = 8'h80;
  localparam logic       ROR_01_Z = 1'b0;
`else
  localparam logic [7:0] ROR_96_3 = 8'h12;
  localparam logic [7:0] ROR_01_1 = 8'h00;
  localparam logic       ROR_01_Z = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  barrel_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] sh,
                                           input logic [1:0] m);
    logic signed [7:0] s;
    logic [15:0]       dd;
    s  = d;
    dd = {d, d} >> sh;
    case (m)
      2'b00:   return d << sh;
      2'b10:   return s >>> sh;
`ifdef BSHIFT_ROTATE_EN
      2'b11:   return dd[7:0];
`endif
      default: return d >> sh;
    endcase
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       z;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   in_acc_cnt = 0;
  int   out_cnt = 0;
  int   acc_cyc [2048];
  int   out_cyc [2048];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // Scoreboard and hold check; samples mid-cycle, describing the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] r;
    cyc++;
    if (rst) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", out_data);
        end else begin
          e = sbq.pop_front();
          check("sb_data", out_data, e.d);
          check("sb_zero", out_zero, e.z);
        end
        out_cyc[out_cnt % 2048] = cyc;
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        r   = ref_shift(in_data, in_shamt, in_mode);
        e.d = r;
        e.z = (r == 8'h00);
        sbq.push_back(e);
        acc_cyc[in_acc_cnt % 2048] = cyc;
        in_acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic [1:0] m;
    logic [7:0] e;
    logic       z;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v.d;
    in_shamt = v.sh;
    in_mode  = v.m;
    check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("vec%0d_latency", idx), n, SHW - 1);
    check($sformatf("vec%0d_data", idx), out_data, v.e);
    check($sformatf("vec%0d_zero", idx), out_zero, v.z);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_drained"}, (n < 50), 1);
  endtask

  initial begin
    int a0, o0, n;
    logic [7:0] held;

    vecs[0]  = '{8'h96, 3'd3, BSH_SLL, 8'hB0, 1'b0};
    vecs[1]  = '{8'h96, 3'd3, BSH_SRL, 8'h12, 1'b0};
    vecs[2]  = '{8'h96, 3'd3, BSH_SRA, 8'hF2, 1'b0};
    vecs[3]  = '{8'h96, 3'd3, BSH_ROR, ROR_96_3, 1'b0};
    vecs[4]  = '{8'h5A, 3'd0, BSH_SLL, 8'h5A, 1'b0};
    vecs[5]  = '{8'h5A, 3'd0, BSH_SRL, 8'h5A, 1'b0};
    vecs[6]  = '{8'h5A, 3'd0, BSH_SRA, 8'h5A, 1'b0};
    vecs[7]  = '{8'h5A, 3'd0, BSH_ROR, 8'h5A, 1'b0};
    vecs[8]  = '{8'h80, 3'd1, BSH_SLL, 8'h00, 1'b1};
    vecs[9]  = '{8'h80, 3'd7, BSH_SRA, 8'hFF, 1'b0};
    vecs[10] = '{8'h01, 3'd1, BSH_ROR, ROR_01_1, ROR_01_Z};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    drain("vec");

    // Back-to-back stream.
    a0 = in_acc_cnt; o0 = out_cnt;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_shamt = 3'($urandom);
      in_mode  = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("b2b");
    check("b2b_accepted", in_acc_cnt - a0, 16);
    check("b2b_delivered", out_cnt - o0, 16);
    check("b2b_first_latency", out_cyc[o0 % 2048] - acc_cyc[a0 % 2048], SHW);
    check("b2b_consecutive", out_cyc[(o0 + 15) % 2048] - out_cyc[o0 % 2048], 15);

    // Stall with a full pipe.
    a0 = in_acc_cnt; o0 = out_cnt;
    out_ready = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_shamt = 3'($urandom);
      in_mode  = 2'($urandom);
      @(posedge clk); #1;
      if (i == 2) held = out_data;
    end
    check("stall_accepted", in_acc_cnt - a0, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_data_stable", out_data, held);
    if (sbq.size() > 0) check("stall_head", out_data, sbq[0].d);
    else check("stall_queue", sbq.size(), 3);
    in_valid = 1'b0;
    drain("stall");
    check("stall_delivered", out_cnt - o0, 3);

    // Random valid/ready toggling.
    a0 = in_acc_cnt; o0 = out_cnt; n = 0;
    while (in_acc_cnt - a0 < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = 8'($urandom);
      in_shamt  = 3'($urandom);
      in_mode   = 2'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("rand_within_budget", (n < 20000), 1);
    drain("rand");
    check("rand_delivered", out_cnt - o0, in_acc_cnt - a0);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C; in_shamt = 3'd1; in_mode = BSH_SLL;
    @(posedge clk); #1;
    in_data = 8'hC3; in_mode = BSH_SRL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 1);
    o0 = out_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_no_stale", out_cnt - o0, 0);
    check("rstmid_idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
